// File: rtl/conv_mac_accumulator.sv
// Signed Q8.8 MAC over one KERNEL_SIZE window plus bias; emits a floor-shifted, optionally ReLU'd, saturated Q8.8 pixel.
// Result valid one cycle after the last beat; input stalls (in_ready=0) while a result waits for out_ready.
module conv_mac_accumulator #(
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_W       = 40
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              pixel_in,
  input  logic [DATA_W-1:0]              weight_in,
  input  logic [DATA_W-1:0]              bias_in,
  input  logic                           relu_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_sat,
  output logic [$clog2(KERNEL_SIZE)-1:0] beat_cnt
);

  localparam int CNT_W  = $clog2(KERNEL_SIZE);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KERNEL_SIZE - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (ACC_W < 2 * DATA_W + $clog2(KERNEL_SIZE) + 2) begin : g_acc_w_check
    $error("conv_mac_accumulator: ACC_W too narrow for KERNEL_SIZE products");
  end

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic signed [DATA_W-1:0] pixel_s, weight_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, acc_next, r;
  logic [DATA_W-1:0]        res_data;
  logic                     res_sat;
  logic                     beat;

  assign pixel_s  = pixel_in;
  assign weight_s = weight_in;
  assign prod     = pixel_s * weight_s;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // Bias is Q8.8; shifting by FRAC_W aligns it with the Q16.16 products.
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias_in[DATA_W-1]}}, bias_in, {FRAC_W{1'b0}}};
  assign beat     = in_valid && in_ready_q;
  assign acc_next = (cnt_q == '0) ? (bias_ext + prod_ext) : (acc_q + prod_ext);
  assign r        = acc_next >>> FRAC_W;

  always_comb begin
    res_data = r[DATA_W-1:0];
    res_sat  = 1'b0;
    if (relu_en && r[ACC_W-1]) begin
      res_data = '0;
    end else if (r > SAT_MAX) begin
      res_data = {1'b0, {(DATA_W-1){1'b1}}};
      res_sat  = 1'b1;
    end else if (r < SAT_MIN) begin
      res_data = {1'b1, {(DATA_W-1){1'b0}}};
      res_sat  = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      S_ACC: begin
        if (beat) begin
          acc_d = acc_next;
          if (cnt_q == LAST_BEAT) begin
            cnt_d       = '0;
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            out_data_d  = res_data;
            out_sat_d   = res_sat;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_ACC;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_ACC;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Directed bench for conv_mac_accumulator: hand-computed Q8.8 windows, latency, backpressure, gaps and reset.
module tb_conv_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pixel_in;
  logic [15:0] weight_in;
  logic [15:0] bias_in;
  logic        relu_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [3:0]  beat_cnt;

  int errors = 0;
  int checks = 0;
  int gap_tbl [9] = '{0, 2, 1, 0, 3, 0, 1, 2, 1};

  conv_mac_accumulator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .weight_in(weight_in), .bias_in(bias_in), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Drives n beats; the first carries b_first as bias, the rest b_rest. Returns at the negedge after the last beat.
  task automatic beats(input int n, input logic [15:0] pix, input logic [15:0] wt,
                       input logic [15:0] b_first, input logic [15:0] b_rest,
                       input logic relu, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        in_valid = 1'b0;
        repeat (gap_tbl[i]) @(negedge clk);
      end
      in_valid  = 1'b1;
      pixel_in  = pix;
      weight_in = wt;
      bias_in   = (i == 0) ? b_first : b_rest;
      relu_en   = relu;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    pixel_in = '0; weight_in = '0; bias_in = '0; relu_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
    checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_ones_latency();
    beats(8, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid got=%b exp=0", out_valid); end
    checks++; if (beat_cnt !== 4'd8) begin errors++; $display("FAIL ones_beat_cnt got=%0d exp=8", beat_cnt); end
    beats(1, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_latency got=%b exp=1", out_valid); end
    checks++; if (out_data !== 16'h0900) begin errors++; $display("FAIL ones_data got=%h exp=0900", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL ones_sat got=%b exp=0", out_sat); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ones_in_ready got=%b exp=0", in_ready); end
    drain();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL ones_handshake got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    checks++; if (out_data !== 16'h0900) begin errors++; $display("FAIL ones_data_retained got=%h exp=0900", out_data); end
  endtask

  task automatic test_bias_sample();
    beats(9, 16'h0100, 16'h0100, 16'h0080, 16'h7FFF, 1'b0, 1'b0);
    checks++; if (out_data !== 16'h0980) begin errors++; $display("FAIL bias_data got=%h exp=0980", out_data); end
    drain();
  endtask

  task automatic test_negative_relu();
    beats(9, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (out_data !== 16'hF700) begin errors++; $display("FAIL neg_data got=%h exp=f700", out_data); end
    drain();
    beats(9, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checks++; if (out_data !== 16'h0000 || out_sat !== 1'b0) begin errors++;
      $display("FAIL relu_data got=%h sat=%b exp=0000 sat=0", out_data, out_sat); end
    drain();
    // -9 LSB of Q16.16 floors to -1 LSB of Q8.8.
    beats(9, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (out_data !== 16'hFFFF || out_sat !== 1'b0) begin errors++;
      $display("FAIL floor_data got=%h sat=%b exp=ffff sat=0", out_data, out_sat); end
    drain();
  endtask

  task automatic test_saturation();
    beats(9, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (out_data !== 16'h7FFF || out_sat !== 1'b1) begin errors++;
      $display("FAIL sat_pos got=%h sat=%b exp=7fff sat=1", out_data, out_sat); end
    drain();
    beats(9, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (out_data !== 16'h8000 || out_sat !== 1'b1) begin errors++;
      $display("FAIL sat_neg got=%h sat=%b exp=8000 sat=1", out_data, out_sat); end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beats(9, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; pixel_in = 16'h7FFF; weight_in = 16'h7FFF; bias_in = 16'h7FFF;
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h0900) begin errors++;
        $display("FAIL bp_hold[%0d] got valid=%b ready=%b data=%h exp valid=1 ready=0 data=0900",
                 c, out_valid, in_ready, out_data); end
    end
    in_valid = 1'b0;
    drain();
    checks++; if (beat_cnt !== 4'd0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_release got cnt=%0d valid=%b exp cnt=0 valid=0", beat_cnt, out_valid); end
    beats(9, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (out_data !== 16'h1200) begin errors++; $display("FAIL bp_next_data got=%h exp=1200", out_data); end
    drain();
  endtask

  task automatic test_gaps();
    // 9 x 1.5 + bias 1.0 = 14.5
    beats(9, 16'h0180, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1);
    checks++; if (out_data !== 16'h0E80) begin errors++; $display("FAIL gaps_data got=%h exp=0e80", out_data); end
    drain();
  endtask

  task automatic test_reset_mid();
    beats(4, 16'h7FFF, 16'h7FFF, 16'h4000, 16'h0000, 1'b0, 1'b0);
    checks++; if (beat_cnt !== 4'd4) begin errors++; $display("FAIL mid_cnt got=%0d exp=4", beat_cnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (beat_cnt !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin errors++;
      $display("FAIL mid_reset got cnt=%0d valid=%b data=%h exp 0/0/0000", beat_cnt, out_valid, out_data); end
    rst = 1'b0;
    @(negedge clk);
    beats(9, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++; if (out_data !== 16'h0900) begin errors++; $display("FAIL mid_fresh_data got=%h exp=0900", out_data); end
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_sat !== 1'b0 || out_data !== 16'h0000) begin errors++;
      $display("FAIL pending_reset got valid=%b sat=%b data=%h exp 0/0/0000", out_valid, out_sat, out_data); end
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pending_reset_ready got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_ones_latency();
    test_bias_sample();
    test_negative_relu();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_mac_accumulator.md
Name: conv_mac_accumulator

Overview:
- Downstream consumer of the 16-bit operand-select muxes in the convolutional layer. It takes one (pixel, weight) pair per accepted beat from the mux outputs and accumulates KERNEL_SIZE signed Q8.8 products plus a bias.
- After the last beat of a kernel window it emits one rounded-down, optionally ReLU'd, saturated 16-bit Q8.8 output pixel.
- Valid/ready handshakes on both sides; one window is processed at a time.

Parameters:
- DATA_W, 16: operand and result width, signed two's complement.
- FRAC_W, 8: fractional bits of operands and result (Q8.8).
- KERNEL_SIZE, 9: products per output (a 3x3 window).
- ACC_W, 40: accumulator width. Must be at least 2*DATA_W + clog2(KERNEL_SIZE) + 2; elaboration fails otherwise.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel/weight/bias valid.
- in_ready  out  1  block can accept a beat.
- pixel_in  in  DATA_W  signed Q8.8 pixel (mux output).
- weight_in  in  DATA_W  signed Q8.8 weight.
- bias_in  in  DATA_W  signed Q8.8 bias; sampled only on the first beat of a window.
- relu_en  in  1  clamp negative results to 0; sampled on the last beat.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  signed Q8.8 result.
- out_sat  out  1  result was clamped by saturation (ReLU clamping does not set it).
- beat_cnt  out  clog2(KERNEL_SIZE)  beats accepted in the current window.

Behaviour:
- Reset (async assert, sync release):
  - state=S_ACC, acc=0, beat_cnt=0.
  - out_valid=0, out_data=0, out_sat=0, in_ready=1 once rst deasserts.
- A beat is accepted when in_valid && in_ready.
- Each accepted beat forms the product p = pixel_in*weight_in as a full signed 2*DATA_W-bit value (Q16.16), sign-extended to ACC_W.
- S_ACC state:
  - in_ready=1, out_valid=0.
  - First beat (beat_cnt==0): acc <= (sext(bias_in) << FRAC_W) + p. Previous acc content is discarded, so no explicit clear is needed.
  - Other beats: acc <= acc + p.
  - beat_cnt increments on each beat.
  - On the beat where beat_cnt==KERNEL_SIZE-1:
    - Compute final sum s = acc_next.
    - Register the result from s into out_data/out_sat.
    - beat_cnt <= 0, state <= S_OUT.
- Result formation, combinational from s and registered at the transition:
  - r = s >>> FRAC_W (arithmetic shift; truncation toward -inf).
  - If relu_en and r<0: out_data=0, out_sat=0.
  - Else if r > 2^(DATA_W-1)-1: out_data=0x7FFF, out_sat=1.
  - Else if r < -2^(DATA_W-1): out_data=0x8000, out_sat=1.
  - Otherwise: out_data=r[DATA_W-1:0], out_sat=0.
- S_OUT state:
  - out_valid=1, in_ready=0.
  - out_data and out_sat are held stable while out_ready=0.
  - On out_valid && out_ready: state <= S_ACC, out_valid deasserts next cycle, and in_ready=1 in that next cycle. out_data retains its last value.
- Latency: the last input beat accepted in cycle N gives out_valid=1 in cycle N+1. Minimum window period is KERNEL_SIZE+1 cycles.
- No overlap: input is stalled while a result is pending; there is no skid buffer.
- in_valid low in S_ACC: acc and beat_cnt hold. Gaps between beats of a window are legal and do not change the result.
- Reset mid-window or with out_valid pending: partial sum and pending result are discarded, all outputs return to reset values, and the next beat is treated as a first beat.
- Accumulator overflow cannot occur at the legal ACC_W; there is no wrap handling.

Test Plan:
- 9 beats, pixel=0x0100, weight=0x0100, bias=0x0000, relu_en=0 -> out_data=0x0900, out_sat=0, out_valid exactly 1 cycle after the 9th beat.
- Same window with bias=0x0080 on beat 1 and bias changed to 0x7FFF on beats 2-9 -> out_data=0x0980 (bias sampled once).
- pixel=0x0100, weight=0xFF00 (-1.0), bias=0 -> relu_en=0 gives 0xF700; relu_en=1 gives 0x0000 with out_sat=0.
- pixel=0x7FFF, weight=0x7FFF ×9 -> out_data=0x7FFF, out_sat=1. pixel=0x8000, weight=0x7FFF ×9, relu_en=0 -> out_data=0x8000, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, in_valid beats ignored. Release -> the next 9-beat window of 0x0200×0x0100 gives 0x1200.
- Gaps and reset: insert random in_valid=0 gaps -> result unchanged. Assert rst after 4 beats -> beat_cnt=0, out_valid=0. A fresh 9-beat window of ones gives 0x0900.
